aes_128_round: RTL and testbench

// - Iterative AES-128 encryption core: one full round (state + key schedule) per clock, 11 cycles per block.
// - Sequencing (round counter, Rcon table) lives in the parent controller, which drives firstRound/final_round/round_const.
// - Sits between the capture host interface and the ciphertext readback register.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sbox.sv | 13 +
 rtl/aes_128_round.sv | 133 +++++++++++++
 tb/tb_aes_128_round.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Package aes_pkg: shared AES-128 constants and GF(2^8) helpers.
//   - SBOX_FLAT / sbox() : forward S-box, byte 0x00 in the top eight bits
//   - xtime()            : multiply by {02} in GF(2^8)
//   - mix_column()       : one MixColumns column, {a0,a1,a2,a3} packed MSB-first
//   - RCON               : round constants for rounds 1..10 (used by controllers/benches)
package aes_pkg;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_FLAT[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        // {03}*x is xtime(x) ^ x
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
//   in_byte  in  8  byte to substitute
//   out_byte out 8  substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_128_round.sv
// aes_128_round: iterative AES-128 encryption datapath, one round plus one
// key-schedule step per clock. The parent controller sequences the block.
//   clk          in   1    rising-edge clock
//   rst          in   1    asynchronous active-low reset
//   data         in   128  plaintext (byte 0 in [127:120]), used on firstRound
//   key          in   128  cipher key, same byte order, used on firstRound
//   firstRound   in   1    load cycle: state <= data ^ key
//   final_round  in   1    last round: no MixColumns, result latched to out
//   round_const  in   8    Rcon for the round computed this cycle
//   out          out  128  registered ciphertext
//   done         out  1    only when AES_128_DONE_EN is defined: one-cycle
//                          pulse aligned with each out update
module aes_128_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data,
    input  logic [127:0] key,
    input  logic         firstRound,
    input  logic         final_round,
    input  logic [7:0]   round_const,
`ifdef AES_128_DONE_EN
    output logic         done,
`endif
    output logic [127:0] out
);

    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;

    // Byte views, byte 0 at index 0; column c holds bytes 4c..4c+3.
    logic [0:15][7:0] st_b;
    logic [7:0]       sb [16];
    logic [0:15][7:0] sr;
    logic [0:15][7:0] mc;

    assign st_b = state_q;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (.in_byte(st_b[i]), .out_byte(sb[i]));
    end

    // ShiftRows: row r of column c takes the byte from column (c + r) mod 4.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4 * c] = sb[r + 4 * ((c + r) % 4)];
            end
        end
    end

    always_comb begin
        logic [31:0] col;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            col = mix_column({sr[4 * c], sr[4 * c + 1], sr[4 * c + 2], sr[4 * c + 3]});
            mc[4 * c]     = col[31:24];
            mc[4 * c + 1] = col[23:16];
            mc[4 * c + 2] = col[15:8];
            mc[4 * c + 3] = col[7:0];
        end
    end

    // Key schedule: SubWord(RotWord(w3)) feeds the next round key.
    logic [31:0] rot_word, sub_word;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;
    logic [127:0] next_key;

    assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (.in_byte(rot_word[8 * j +: 8]), .out_byte(sub_word[8 * j +: 8]));
    end

    assign w0_n     = rkey_q[127:96] ^ sub_word ^ {round_const, 24'h0};
    assign w1_n     = rkey_q[95:64] ^ w0_n;
    assign w2_n     = rkey_q[63:32] ^ w1_n;
    assign w3_n     = rkey_q[31:0] ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // firstRound has priority over final_round; with neither asserted the
    // core keeps running middle rounds.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d = state_q;
        rkey_d  = rkey_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (firstRound) begin
            state_d = data ^ key;
            rkey_d  = key;
        end else if (final_round) begin
            state_d = sr ^ next_key;
            rkey_d  = next_key;
            out_d   = sr ^ next_key;
            done_d  = 1'b1;
        end else begin
            state_d = mc ^ next_key;
            rkey_d  = next_key;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep all registers sampling the same
        // pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= '0;
            rkey_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out = out_q;

`ifdef AES_128_DONE_EN
    assign done = done_q;
`else
    // Pulse is only exported when the done port exists.
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_aes_128_round.sv
// Self-checking bench for aes_128_round: FIPS-197 vectors, back-to-back
// blocks, abort, mid-block reset and the firstRound/final_round overlap.
// Build with AES_128_DONE_EN defined to also check the done pulse.
module tb_aes_128_round;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] data = '0;
    logic [127:0] key = '0;
    logic         first_round = 1'b0;
    logic         final_round = 1'b0;
    logic [7:0]   round_const = '0;
    logic [127:0] out;
`ifdef AES_128_DONE_EN
    logic         done;
`endif

    aes_128_round dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .key        (key),
        .firstRound (first_round),
        .final_round(final_round),
        .round_const(round_const),
`ifdef AES_128_DONE_EN
        .done       (done),
`endif
        .out        (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] exp;
        logic         has_r1;
        logic [127:0] r1;
    } vec_t;

    vec_t vecs [4];

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q [$];
    logic [127:0] held = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance past the edge, then check out (and done).
    task automatic step(input string tag, input logic fr, input logic fin, input logic [7:0] rc,
                        input logic [127:0] d, input logic [127:0] k);
        first_round = fr;
        final_round = fin;
        round_const = rc;
        data        = d;
        key         = k;
        @(posedge clk);
        #1;
        if (fin && !fr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: scoreboard empty at output", tag);
            end else begin
                held = exp_q.pop_front();
            end
        end
        check({tag, "_out"}, out, held);
`ifdef AES_128_DONE_EN
        check({tag, "_done"}, {127'h0, done}, {127'h0, fin && !fr});
`endif
    endtask

    task automatic run_block(input vec_t v, input logic both_first);
        step({v.name, "_load"}, 1'b1, both_first, 8'h00, v.data, v.key);
        check({v.name, "_load_state"}, dut.state_q, v.data ^ v.key);
        for (int r = 0; r < 9; r++) begin
            step({v.name, "_mid"}, 1'b0, 1'b0, RCON[r], '0, '0);
            if (r == 0 && v.has_r1) check({v.name, "_round1_state"}, dut.state_q, v.r1);
        end
        exp_q.push_back(v.exp);
        step({v.name, "_final"}, 1'b0, 1'b1, RCON[9], '0, '0);
    endtask

    // Load plus n_mid middle rounds, leaving the block unfinished.
    task automatic partial(input vec_t v, input int n_mid);
        step({v.name, "_pload"}, 1'b1, 1'b0, 8'h00, v.data, v.key);
        for (int r = 0; r < n_mid; r++) step({v.name, "_pmid"}, 1'b0, 1'b0, RCON[r], '0, '0);
    endtask

    initial begin
        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, '0};
        vecs[1] = '{"fipsb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1,
                    128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[2] = '{"zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0, '0};
        vecs[3] = vecs[2];
        vecs[3].name = "zero_b2b";

        // Reset state
        #12;
        check("reset_out", out, '0);
        check("reset_state", dut.state_q, '0);
        check("reset_rkey", dut.rkey_q, '0);
        rst = 1'b1;

        // Table-driven blocks; the last two run back-to-back with out held between
        for (int i = 0; i < 4; i++) run_block(vecs[i], 1'b0);

        // Abort a block with a new firstRound; out keeps the last ciphertext
        partial(vecs[1], 3);
        run_block(vecs[0], 1'b0);

        // firstRound and final_round together: load wins, out unchanged
        run_block(vecs[1], 1'b1);

        // Reset in the middle of round 5
        partial(vecs[2], 4);
        #3;
        rst = 1'b0;
        #1;
        held = '0;
        check("midreset_out", out, '0);
        check("midreset_state", dut.state_q, '0);
        #2;
        rst = 1'b1;
        run_block(vecs[0], 1'b0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
